// File: rtl/rice_core_pkg.sv
// ============================================================================
// Module   : rice_core_pkg
// Purpose  : Shared types for the rice_core pipeline controller:
//            - RICE_CORE_DEFINE_TYPES(W) macro, which declares the PC type pc_t
//            - rice_core_pipeline_ctrl_state, the controller state encoding
//            - the flush-counter load value helper
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef RICE_CORE_DEFINE_TYPES_SVH
`define RICE_CORE_DEFINE_TYPES_SVH
`define RICE_CORE_DEFINE_TYPES(W) typedef logic [(W)-1:0] pc_t;
`endif

package rice_core_pkg;

   // The encoding is visible on o_state, so the values are fixed.
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_STALL = 2'd3
   } rice_core_pipeline_ctrl_state;

   localparam int unsigned C_FLUSH_CYCLES_MAX = 3;

   // Value loaded into the flush down-counter.
   // The flush bubble ends on the cycle the counter reads 0.
   function automatic logic [1:0] flush_cnt_init(input int unsigned cycles);
      return 2'(cycles - 1);
   endfunction

endpackage : rice_core_pkg

`default_nettype wire

// File: rtl/rice_core_pipeline_if.sv
// ============================================================================
// Module   : rice_core_pipeline_if
// Purpose  : Pipeline control bundle from the controller to IF/ID.
// Signals  : stall    - hold IF/ID
//            flush    - squash IF/ID
//            flush_pc - redirect PC for IF
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rice_core_pipeline_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            flush;
   logic [XLEN-1:0] flush_pc;
endinterface : rice_core_pipeline_if

`default_nettype wire

// File: rtl/rice_core_sat_counter.sv
// ============================================================================
// Module   : rice_core_sat_counter
// Purpose  : Event counter that saturates at all-ones.
//            It uses an asynchronous active-high reset.
// Ports    : i_clk - clock
//            i_rst - asynchronous active-high reset; clears the count
//            inc   - increment request for this cycle
//            count - current count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rice_core_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : rice_core_sat_counter

`default_nettype wire

// File: rtl/rice_core_pipeline_ctrl.sv
// ============================================================================
// Module   : rice_core_pipeline_ctrl
// Purpose  : Pipeline hazard controller.
//            - Requests are resolved with priority trap > flush > stall.
//            - Trap and flush redirects produce a registered flush bubble
//              of FLUSH_CYCLES cycles.
//            - Stall is asserted combinationally.
// Ports    : i_clk, i_rst (asynchronous, active-high)
//            i_stall_req, i_flush_req/i_flush_pc, i_trap_req/i_trap_pc
//            o_stall, o_flush, o_flush_pc, o_state
//            o_stall_count, o_flush_count
//              - present only when RICE_CORE_PIPELINE_CTRL_PERF_EN
//                is defined
// Params   : XLEN, RESET_PC, FLUSH_CYCLES (legal range 1..3)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rice_core_pipeline_ctrl
   import rice_core_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
   parameter int              FLUSH_CYCLES = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stall_req,
   input  logic            i_flush_req,
   input  logic [XLEN-1:0] i_flush_pc,
   input  logic            i_trap_req,
   input  logic [XLEN-1:0] i_trap_pc,
   output logic            o_stall,
   output logic            o_flush,
   output logic [XLEN-1:0] o_flush_pc,
   output logic [1:0]      o_state
`ifdef RICE_CORE_PIPELINE_CTRL_PERF_EN
   ,
   output logic [31:0]     o_stall_count,
   output logic [31:0]     o_flush_count
`endif
);

   `RICE_CORE_DEFINE_TYPES(XLEN)

   localparam logic [1:0] C_CNT_INIT = flush_cnt_init(FLUSH_CYCLES);

   rice_core_pipeline_ctrl_state state_q, state_d;
   pc_t                          flush_pc_q, flush_pc_d;
   logic [1:0]                   cnt_q, cnt_d;
   logic                         flush_q;
   logic                         stall_w;

   rice_core_pipeline_if #(.XLEN(XLEN)) pipe_if ();

   always_comb begin
      state_d    = state_q;
      flush_pc_d = flush_pc_q;
      cnt_d      = cnt_q;
      stall_w    = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d    = ST_FLUSH;
            flush_pc_d = RESET_PC;
            cnt_d      = C_CNT_INIT;
         end
         ST_RUN, ST_STALL: begin
            if (i_trap_req) begin
               state_d    = ST_FLUSH;
               flush_pc_d = {i_trap_pc[XLEN-1:1], 1'b0};
               cnt_d      = C_CNT_INIT;
            end else if (i_flush_req) begin
               state_d    = ST_FLUSH;
               flush_pc_d = {i_flush_pc[XLEN-1:1], 1'b0};
               cnt_d      = C_CNT_INIT;
            end else if (i_stall_req) begin
               stall_w = 1'b1;
               state_d = ST_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // A trap restarts the bubble toward the new vector.
            // A branch redirect is dropped here because the bubble
            // already squashes the wrong path.
            if (i_trap_req) begin
               flush_pc_d = {i_trap_pc[XLEN-1:1], 1'b0};
               cnt_d      = C_CNT_INIT;
            end else if (cnt_q == 2'd0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_BOOT;
         flush_pc_q <= RESET_PC;
         cnt_q      <= 2'd0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         flush_pc_q <= flush_pc_d;
         cnt_q      <= cnt_d;
         flush_q    <= (state_d == ST_FLUSH);
      end
   end

   assign pipe_if.stall    = stall_w;
   assign pipe_if.flush    = flush_q;
   assign pipe_if.flush_pc = flush_pc_q;

   assign o_stall    = pipe_if.stall;
   assign o_flush    = pipe_if.flush;
   assign o_flush_pc = pipe_if.flush_pc;
   assign o_state    = state_q;

`ifdef RICE_CORE_PIPELINE_CTRL_PERF_EN
   // Every FLUSH entry is counted as an event.
   // A trap relatch while already in FLUSH counts as a new entry.
   logic flush_entry_w;
   assign flush_entry_w = (state_d == ST_FLUSH) &&
                          ((state_q != ST_FLUSH) || i_trap_req);

   rice_core_sat_counter #(.WIDTH(32)) u_stall_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .inc   (stall_w),
      .count (o_stall_count)
   );

   rice_core_sat_counter #(.WIDTH(32)) u_flush_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .inc   (flush_entry_w),
      .count (o_flush_count)
   );
`endif

endmodule : rice_core_pipeline_ctrl

`default_nettype wire
